// File: rtl/control_fsm.sv
// control_fsm: instruction-sequencing controller for a 16-bit load/store datapath.
// Steps each instruction through fetch, decode and execute, issues the datapath
// register loads and mux selects, and handshakes memory requests with a bounded
// wait. A request that is not answered within the wait budget parks the
// controller in ERROR until reset.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   run                   level; leaves HALTED when high
//   opcode                IR[15:12] from the datapath
//   imm5_sel, jsr_sel     IR[5], IR[11] (not needed by this decode)
//   branch_enable         NZP condition match
//   mem_resp              one-cycle memory completion strobe
//   LD_PC .. load_cc      datapath register loads
//   PCMUX, DRMUX, ADDR2MUX, alumux_sel, MARMUX, ADDR1MUX, aluop, gate_sel
//                         datapath mux / ALU selects
//   mem_read, mem_write   memory request, held until mem_resp
//   halted, error         status flags
//
// state    | meaning
// ---------+------------------------------------------------
// HALTED   | idle, waiting for run
// FETCH1   | MAR <- PC, PC <- PC + 1
// FETCH2   | instruction read, waiting for mem_resp
// FETCH3   | IR <- MDR
// DECODE   | dispatch on opcode
// EXEC     | ALU, branch, jump, subroutine-call execution
// MEM_ADDR | MAR <- base + offset6 for LDR/STR
// MEM_RD   | data read, waiting for mem_resp
// MEM_WR   | data write, waiting for mem_resp
// WB       | register file <- MDR
// ERROR    | illegal opcode or memory timeout; left only by reset
module control_fsm #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [3:0] opcode,
   input  logic       imm5_sel,
   input  logic       jsr_sel,
   input  logic       branch_enable,
   input  logic       mem_resp,
   output logic       LD_PC,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       load_regfile,
   output logic       load_cc,
   output logic [1:0] PCMUX,
   output logic [1:0] DRMUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] alumux_sel,
   output logic       MARMUX,
   output logic       ADDR1MUX,
   output logic [3:0] aluop,
   output logic [1:0] gate_sel,
   output logic       mem_read,
   output logic       mem_write,
   output logic       halted,
   output logic       error
);

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_HALT = 4'b1101;

   localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

   typedef enum logic [3:0] {
      S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_EXEC,
      S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB, S_ERROR
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] wait_cnt;
   logic       waiting;
   logic       timeout;

   // Register-destination and immediate selection happen in the datapath;
   // the sequencing here does not depend on these IR bits.
   logic unused_ir_bits;
   assign unused_ir_bits = imm5_sel ^ jsr_sel;

   assign waiting = (state == S_FETCH2 || state == S_MEM_RD || state == S_MEM_WR) && !mem_resp;
   assign timeout = (wait_cnt == WAIT_LIM);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_HALTED;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         // Any state change clears the count, so each wait state starts at 0.
         if (state_nxt != state) wait_cnt <= '0;
         else if (waiting)       wait_cnt <= wait_cnt + 4'd1;
      end
   end

   always_comb begin
      state_nxt    = state;
      LD_PC        = 1'b0;
      LD_MAR       = 1'b0;
      LD_MDR       = 1'b0;
      LD_IR        = 1'b0;
      load_regfile = 1'b0;
      load_cc      = 1'b0;
      PCMUX        = 2'b00;
      DRMUX        = 2'b00;
      ADDR2MUX     = 2'b00;
      alumux_sel   = 2'b00;
      MARMUX       = 1'b0;
      ADDR1MUX     = 1'b0;
      aluop        = 4'b0000;
      gate_sel     = 2'b00;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      halted       = 1'b0;
      error        = 1'b0;

      unique case (state)
         S_HALTED: begin
            halted = 1'b1;
            if (run) state_nxt = S_FETCH1;
         end
         S_FETCH1: begin
            ADDR2MUX  = 2'b11;
            LD_MAR    = 1'b1;
            LD_PC     = 1'b1;
            state_nxt = S_FETCH2;
         end
         S_FETCH2: begin
            mem_read = 1'b1;
            // A response in the timeout cycle still wins.
            if (mem_resp) begin
               LD_MDR    = 1'b1;
               state_nxt = S_FETCH3;
            end else if (timeout) begin
               state_nxt = S_ERROR;
            end
         end
         S_FETCH3: begin
            gate_sel  = 2'b01;
            LD_IR     = 1'b1;
            state_nxt = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP, OP_JSR: state_nxt = S_EXEC;
               OP_LDR, OP_STR:                                state_nxt = S_MEM_ADDR;
               OP_HALT:                                       state_nxt = S_HALTED;
               default:                                       state_nxt = S_ERROR;
            endcase
         end
         S_EXEC: begin
            case (opcode)
               OP_ADD, OP_AND, OP_NOT: begin
                  aluop        = (opcode == OP_ADD) ? 4'b0000 :
                                 (opcode == OP_AND) ? 4'b0001 : 4'b0010;
                  gate_sel     = 2'b10;
                  load_regfile = 1'b1;
                  load_cc      = 1'b1;
               end
               OP_BR: begin
                  if (branch_enable) begin
                     LD_PC    = 1'b1;
                     PCMUX    = 2'b10;
                     ADDR2MUX = 2'b01;
                  end
               end
               OP_JMP: begin
                  PCMUX    = 2'b10;
                  ADDR1MUX = 1'b1;
                  ADDR2MUX = 2'b11;
                  LD_PC    = 1'b1;
               end
               OP_JSR: begin
                  // Return address (old PC) goes to R7 while PC takes the target.
                  gate_sel     = 2'b00;
                  load_regfile = 1'b1;
                  PCMUX        = 2'b10;
                  LD_PC        = 1'b1;
               end
               default: ;
            endcase
            state_nxt = S_FETCH1;
         end
         S_MEM_ADDR: begin
            ADDR1MUX  = 1'b1;
            ADDR2MUX  = 2'b10;
            LD_MAR    = 1'b1;
            state_nxt = (opcode == OP_STR) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            if (mem_resp) begin
               LD_MDR    = 1'b1;
               state_nxt = S_WB;
            end else if (timeout) begin
               state_nxt = S_ERROR;
            end
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            if (mem_resp)     state_nxt = S_FETCH1;
            else if (timeout) state_nxt = S_ERROR;
         end
         S_WB: begin
            gate_sel     = 2'b01;
            load_regfile = 1'b1;
            load_cc      = 1'b1;
            state_nxt    = S_FETCH1;
         end
         S_ERROR: begin
            error = 1'b1;
         end
         default: state_nxt = S_ERROR;
      endcase
   end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: drives control_fsm cycle by cycle and compares every output
// against an expected trace built from instruction-level rules.
module tb_control_fsm;

   localparam int WAIT_MAX = 15;

   logic       clk = 1'b0;
   logic       reset, run, imm5_sel, jsr_sel, branch_enable, mem_resp;
   logic [3:0] opcode;
   logic       LD_PC, LD_MAR, LD_MDR, LD_IR, load_regfile, load_cc;
   logic [1:0] PCMUX, DRMUX, ADDR2MUX, alumux_sel, gate_sel;
   logic       MARMUX, ADDR1MUX, mem_read, mem_write, halted, error;
   logic [3:0] aluop;

   control_fsm #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode),
      .imm5_sel(imm5_sel), .jsr_sel(jsr_sel), .branch_enable(branch_enable),
      .mem_resp(mem_resp),
      .LD_PC(LD_PC), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR),
      .load_regfile(load_regfile), .load_cc(load_cc),
      .PCMUX(PCMUX), .DRMUX(DRMUX), .ADDR2MUX(ADDR2MUX), .alumux_sel(alumux_sel),
      .MARMUX(MARMUX), .ADDR1MUX(ADDR1MUX), .aluop(aluop), .gate_sel(gate_sel),
      .mem_read(mem_read), .mem_write(mem_write), .halted(halted), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       ld_pc, ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc;
      logic [1:0] pcmux, drmux, addr2mux, alumux;
      logic       marmux, addr1mux;
      logic [3:0] aluop;
      logic [1:0] gate;
      logic       mem_read, mem_write, halted, error;
   } outs_t;

   typedef struct {
      outs_t    exp;
      bit [3:0] op;
      bit       br;
      bit       resp;
      bit       runv;
   } rec_t;

   outs_t act;
   assign act = {LD_PC, LD_MAR, LD_MDR, LD_IR, load_regfile, load_cc,
                 PCMUX, DRMUX, ADDR2MUX, alumux_sel, MARMUX, ADDR1MUX,
                 aluop, gate_sel, mem_read, mem_write, halted, error};

   int       total = 0;
   int       bad   = 0;
   rec_t     q[$];
   bit [3:0] cur_op;
   bit       cur_br;

   function automatic bit rnd_bit();
      return bit'($urandom_range(0, 1));
   endfunction

   task automatic push(input outs_t e, input bit resp, input bit runv);
      rec_t r;
      r.exp = e; r.op = cur_op; r.br = cur_br; r.resp = resp; r.runv = runv;
      q.push_back(r);
   endtask

   task automatic push_halted(input bit runv);
      outs_t o;
      o = '0; o.halted = 1'b1;
      push(o, rnd_bit(), runv);
   endtask

   task automatic push_error();
      outs_t o;
      o = '0; o.error = 1'b1;
      push(o, rnd_bit(), rnd_bit());
   endtask

   // A memory access answered after w idle cycles; w beyond the budget never answers.
   task automatic m_wait(input int w, input bit rd, output bit ok);
      outs_t o;
      for (int k = 0; k < w && k <= WAIT_MAX; k++) begin
         o = '0; o.mem_read = rd; o.mem_write = !rd;
         push(o, 1'b0, rnd_bit());
      end
      if (w <= WAIT_MAX) begin
         o = '0; o.mem_read = rd; o.mem_write = !rd; o.ld_mdr = rd;
         push(o, 1'b1, rnd_bit());
         ok = 1'b1;
      end else begin
         push_error();
         ok = 1'b0;
      end
   endtask

   // res: 0 = continues to next fetch, 1 = halts, 2 = ends in ERROR
   task automatic m_instr(input bit [3:0] op, input bit br, input int w1, input int w2,
                          output int res);
      outs_t o;
      bit    ok;
      res = 0; cur_op = op; cur_br = br;
      o = '0; o.ld_mar = 1'b1; o.ld_pc = 1'b1; o.addr2mux = 2'b11;
      push(o, rnd_bit(), rnd_bit());
      m_wait(w1, 1'b1, ok);
      if (!ok) begin res = 2; return; end
      o = '0; o.gate = 2'b01; o.ld_ir = 1'b1;
      push(o, rnd_bit(), rnd_bit());
      o = '0;
      push(o, rnd_bit(), rnd_bit());
      o = '0;
      case (op)
         4'b0001, 4'b0101, 4'b1001: begin
            o.aluop = (op == 4'b0001) ? 4'd0 : (op == 4'b0101) ? 4'd1 : 4'd2;
            o.gate = 2'b10; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
            push(o, rnd_bit(), rnd_bit());
         end
         4'b0000: begin
            if (br) begin o.ld_pc = 1'b1; o.pcmux = 2'b10; o.addr2mux = 2'b01; end
            push(o, rnd_bit(), rnd_bit());
         end
         4'b1100: begin
            o.pcmux = 2'b10; o.addr1mux = 1'b1; o.addr2mux = 2'b11; o.ld_pc = 1'b1;
            push(o, rnd_bit(), rnd_bit());
         end
         4'b0100: begin
            o.ld_reg = 1'b1; o.pcmux = 2'b10; o.ld_pc = 1'b1;
            push(o, rnd_bit(), rnd_bit());
         end
         4'b0110, 4'b0111: begin
            o.addr1mux = 1'b1; o.addr2mux = 2'b10; o.ld_mar = 1'b1;
            push(o, rnd_bit(), rnd_bit());
            m_wait(w2, op == 4'b0110, ok);
            if (!ok) begin res = 2; return; end
            if (op == 4'b0110) begin
               o = '0; o.gate = 2'b01; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
               push(o, rnd_bit(), rnd_bit());
            end
         end
         4'b1101: res = 1;
         default: begin push_error(); res = 2; end
      endcase
   endtask

   task automatic drive_rec(input rec_t r);
      reset = 1'b0; opcode = r.op; branch_enable = r.br;
      mem_resp = r.resp; run = r.runv;
      imm5_sel = rnd_bit(); jsr_sel = rnd_bit();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      reset = 1'b1; run = 1'b0; mem_resp = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      outs_t e;
      e = '0; e.halted = 1'b1;
      for (int i = 0; i < 5; i++) begin
         reset = (i < 3); run = (i < 3); mem_resp = rnd_bit(); opcode = 4'($urandom);
         @(negedge clk);
         total++;
         if (act !== e) begin bad++; $display("FAIL reset cycle %0d: got %h want %h", i, act, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_add();
      int res;
      apply_reset(); q.delete();
      push_halted(1'b1);
      m_instr(4'b0001, 1'b0, 2, 0, res);
      for (int i = 0; i < q.size(); i++) begin
         drive_rec(q[i]); total++;
         if (act !== q[i].exp) begin bad++; $display("FAIL add cycle %0d: got %h want %h", i, act, q[i].exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      int res;
      apply_reset(); q.delete();
      push_halted(1'b1);
      m_instr(4'b0000, 1'b0, 0, 0, res);
      m_instr(4'b0000, 1'b1, 1, 0, res);
      m_instr(4'b1100, 1'b0, 0, 0, res);
      m_instr(4'b0100, 1'b1, 3, 0, res);
      for (int i = 0; i < q.size(); i++) begin
         drive_rec(q[i]); total++;
         if (act !== q[i].exp) begin bad++; $display("FAIL branch cycle %0d: got %h want %h", i, act, q[i].exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_ldr_str();
      int res;
      apply_reset(); q.delete();
      push_halted(1'b1);
      m_instr(4'b0110, 1'b0, 1, 1, res);
      m_instr(4'b0111, 1'b0, 0, 1, res);
      m_instr(4'b0110, 1'b0, 0, 0, res);
      for (int i = 0; i < q.size(); i++) begin
         drive_rec(q[i]); total++;
         if (act !== q[i].exp) begin bad++; $display("FAIL ldr_str cycle %0d: got %h want %h", i, act, q[i].exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      int res;
      for (int t = 0; t < 3; t++) begin
         apply_reset(); q.delete();
         push_halted(1'b1);
         case (t)
            0: m_instr(4'b0001, 1'b0, WAIT_MAX + 1, 0, res);
            1: m_instr(4'b0110, 1'b0, 0, WAIT_MAX + 1, res);
            default: m_instr(4'b0111, 1'b0, 2, WAIT_MAX + 1, res);
         endcase
         for (int k = 0; k < 3; k++) push_error();
         for (int i = 0; i < q.size(); i++) begin
            drive_rec(q[i]); total++;
            if (act !== q[i].exp) begin bad++; $display("FAIL timeout%0d cycle %0d: got %h want %h", t, i, act, q[i].exp); end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_resp_boundary();
      int res;
      apply_reset(); q.delete();
      push_halted(1'b1);
      m_instr(4'b0101, 1'b0, WAIT_MAX, 0, res);
      m_instr(4'b0111, 1'b0, WAIT_MAX - 1, WAIT_MAX, res);
      m_instr(4'b0110, 1'b0, 0, WAIT_MAX, res);
      for (int i = 0; i < q.size(); i++) begin
         drive_rec(q[i]); total++;
         if (act !== q[i].exp) begin bad++; $display("FAIL boundary cycle %0d: got %h want %h", i, act, q[i].exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_wait();
      int    res;
      outs_t e;
      apply_reset(); q.delete();
      push_halted(1'b1);
      m_instr(4'b0111, 1'b0, 0, WAIT_MAX + 1, res);
      // keep only up to the third cycle of the write wait
      while (q.size() > 1 + 1 + 1 + 2 + 1 + 3) void'(q.pop_back());
      for (int i = 0; i < q.size(); i++) begin
         drive_rec(q[i]); total++;
         if (act !== q[i].exp) begin bad++; $display("FAIL midwait cycle %0d: got %h want %h", i, act, q[i].exp); end
         @(posedge clk); #1;
      end
      reset = 1'b1; run = 1'b1; mem_resp = 1'b0;
      e = '0; e.mem_write = 1'b1;
      @(negedge clk); total++;
      if (act !== e) begin bad++; $display("FAIL midwait reset cycle: got %h want %h", act, e); end
      @(posedge clk); #1;
      reset = 1'b0; run = 1'b0;
      e = '0; e.halted = 1'b1;
      @(negedge clk); total++;
      if (act !== e) begin bad++; $display("FAIL midwait after reset: got %h want %h", act, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_pause_illegal();
      int res;
      apply_reset(); q.delete();
      push_halted(1'b1);
      m_instr(4'b1101, 1'b0, 0, 0, res);
      push_halted(1'b0); push_halted(1'b0); push_halted(1'b1);
      m_instr(4'b1001, 1'b0, 1, 0, res);
      m_instr(4'b1000, 1'b0, 0, 0, res);
      push_error(); push_error();
      for (int i = 0; i < q.size(); i++) begin
         drive_rec(q[i]); total++;
         if (act !== q[i].exp) begin bad++; $display("FAIL pause_illegal cycle %0d: got %h want %h", i, act, q[i].exp); end
         @(posedge clk); #1;
      end
      apply_reset(); q.delete();
      push_halted(1'b1);
      m_instr(4'b1111, 1'b0, 0, 0, res);
      push_error();
      for (int i = 0; i < q.size(); i++) begin
         drive_rec(q[i]); total++;
         if (act !== q[i].exp) begin bad++; $display("FAIL illegal_1111 cycle %0d: got %h want %h", i, act, q[i].exp); end
         @(posedge clk); #1;
      end
   endtask

   function automatic int pick_wait();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return WAIT_MAX;
      if (r == 1) return WAIT_MAX - 1;
      return int'($urandom_range(0, 4));
   endfunction

   task automatic test_random();
      int       res;
      bit [3:0] legal [9];
      bit [3:0] op;
      legal = '{4'b0001, 4'b0101, 4'b1001, 4'b0000, 4'b1100, 4'b0100, 4'b0110, 4'b0111, 4'b1101};
      apply_reset(); q.delete();
      push_halted(1'b1);
      for (int n = 0; n < 40; n++) begin
         op = legal[$urandom_range(0, 8)];
         m_instr(op, rnd_bit(), pick_wait(), pick_wait(), res);
         if (res == 1) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) push_halted(1'b0);
            push_halted(1'b1);
         end
      end
      for (int i = 0; i < q.size(); i++) begin
         drive_rec(q[i]); total++;
         if (act !== q[i].exp) begin bad++; $display("FAIL random cycle %0d op %b: got %h want %h", i, q[i].op, act, q[i].exp); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; opcode = '0; imm5_sel = 1'b0; jsr_sel = 1'b0;
      branch_enable = 1'b0; mem_resp = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_add();
      test_branch();
      test_ldr_str();
      test_timeout();
      test_resp_boundary();
      test_reset_mid_wait();
      test_pause_illegal();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
